// File: rtl/dual_port_ram_clr.sv
// dual_port_ram_clr: true dual-port RAM with registered reads on both ports and
// a hardware clear engine that sweeps every word with a fill value.
// Port A serves the game-object FSMs, port B the video pixel generator.
// Optional build macro DPRAM_PARITY_EN: each word carries an even-parity bit and
// the ports parity_err_a / parity_err_b report a mismatch on every read.
module dual_port_ram_clr #(
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 2,
    parameter int RDW_MODE   = 0      // 0 = read-first (old data), 1 = write-first (new data)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  we_a,
    input  logic [ADDR_WIDTH-1:0] addr_a,
    input  logic [DATA_WIDTH-1:0] din_a,
    output logic [DATA_WIDTH-1:0] dout_a,
    input  logic                  we_b,
    input  logic [ADDR_WIDTH-1:0] addr_b,
    input  logic [DATA_WIDTH-1:0] din_b,
    output logic [DATA_WIDTH-1:0] dout_b,
    input  logic                  clr_start,
    input  logic [DATA_WIDTH-1:0] clr_value,
    output logic                  clr_busy,
`ifdef DPRAM_PARITY_EN
    output logic                  clr_done,
    output logic                  parity_err_a,
    output logic                  parity_err_b
`else
    output logic                  clr_done
`endif
);

    localparam int DEPTH = 2 ** ADDR_WIDTH;
`ifdef DPRAM_PARITY_EN
    localparam int WORD_WIDTH = DATA_WIDTH + 1;   // {parity, data}
`else
    localparam int WORD_WIDTH = DATA_WIDTH;
`endif
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

    typedef logic [WORD_WIDTH-1:0] word_t;
    typedef enum logic [1:0] {IDLE, CLEAR, DONE} clr_state_t;

    // Stored form of a data word: the parity bit (when present) makes the XOR of
    // the whole stored word zero.
    function automatic word_t encode(input logic [DATA_WIDTH-1:0] data);
`ifdef DPRAM_PARITY_EN
        return {^data, data};
`else
        return data;
`endif
    endfunction

    word_t                 mem [DEPTH];

    clr_state_t            state;
    logic [ADDR_WIDTH-1:0] clr_addr;
    logic [DATA_WIDTH-1:0] clr_fill;
    logic                  clearing;

    // Two physical write slots per cycle: slot 0 carries the clear engine or
    // port A, slot 1 carries port B. Slot 1 is never enabled on slot 0's address.
    logic                  wr0_en;
    logic [ADDR_WIDTH-1:0] wr0_addr;
    word_t                 wr0_data;
    logic                  wr1_en;
    logic [ADDR_WIDTH-1:0] wr1_addr;
    word_t                 wr1_data;

    word_t                 rd_a_word;
    word_t                 rd_b_word;

    // Resolve which writes commit this cycle: the sweep owns the array, otherwise
    // port A wins an address collision and port B's data is dropped.
    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned
        // and no latch is inferred.
        clearing = (state == CLEAR) && !reset;
        wr0_en   = 1'b0;
        wr0_addr = addr_a;
        wr0_data = encode(din_a);
        wr1_en   = 1'b0;
        wr1_addr = addr_b;
        wr1_data = encode(din_b);
        if (clearing) begin
            wr0_en   = 1'b1;
            wr0_addr = clr_addr;
            wr0_data = encode(clr_fill);
        end else begin
            wr0_en = we_a;
            wr1_en = we_b && !(we_a && (addr_a == addr_b));
        end
    end

    // Array write port; contents survive reset so the frame buffer is untouched.
    // NOTE: the memory array has no reset branch -- a reset would turn the RAM
    // into thousands of flops; only the sweep engine initialises it.
    always_ff @(posedge clk) begin
        if (wr0_en) mem[wr0_addr] <= wr0_data;
        if (wr1_en) mem[wr1_addr] <= wr1_data;
    end

    // Next read word per port: the stored word, or in write-first mode the word
    // being committed to that same address this cycle by any writer.
    always_comb begin
        rd_a_word = mem[addr_a];
        rd_b_word = mem[addr_b];
        if (RDW_MODE != 0) begin
            if (wr1_en && (wr1_addr == addr_a)) rd_a_word = wr1_data;
            if (wr0_en && (wr0_addr == addr_a)) rd_a_word = wr0_data;
            if (wr1_en && (wr1_addr == addr_b)) rd_b_word = wr1_data;
            if (wr0_en && (wr0_addr == addr_b)) rd_b_word = wr0_data;
        end
    end

    // Registered read data (and parity check) for both ports.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            dout_a       <= '0;
            dout_b       <= '0;
`ifdef DPRAM_PARITY_EN
            parity_err_a <= 1'b0;
            parity_err_b <= 1'b0;
`endif
        end else begin
            dout_a       <= rd_a_word[DATA_WIDTH-1:0];
            dout_b       <= rd_b_word[DATA_WIDTH-1:0];
`ifdef DPRAM_PARITY_EN
            parity_err_a <= ^rd_a_word;
            parity_err_b <= ^rd_b_word;
`endif
        end
    end

    // Clear sequencer: IDLE waits for a request, CLEAR writes one word per cycle
    // from address 0 to the last address, DONE pulses clr_done for one cycle.
    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            clr_addr <= '0;
            clr_fill <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    clr_done <= 1'b0;
                    if (clr_start) begin
                        state    <= CLEAR;
                        clr_addr <= '0;
                        clr_fill <= clr_value;
                        clr_busy <= 1'b1;
                    end
                end
                CLEAR: begin
                    // Terminal compare stops the sweep before the counter could wrap.
                    if (clr_addr == LAST_ADDR) begin
                        state    <= DONE;
                        clr_addr <= '0;
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                    end else begin
                        clr_addr <= clr_addr + 1'b1;
                    end
                end
                DONE: begin
                    state    <= IDLE;
                    clr_done <= 1'b0;
                end
                default: begin
                    state    <= IDLE;
                    clr_busy <= 1'b0;
                    clr_done <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: doc/dual_port_ram_clr.md
Name: dual_port_ram_clr

Overview:
- Parametrised true-dual-port RAM for pixel/tile storage, e.g. a frame buffer between the game-logic writer and the VGA pixel reader.
- Both ports can read and write, and read data is registered.
- A hardware clear engine sweeps the whole array with a fill value, so a new game level can blank the screen without CPU/FSM loops.
- Sits between the game object FSMs (port A) and the video pixel generator (port B).

Parameters:
- ADDR_WIDTH, 12, address bits per port; depth = 2**ADDR_WIDTH.
- DATA_WIDTH, 2, bits per word (colour code).
- RDW_MODE, 0, read-during-write result: 0 = old data (read-first), 1 = new data (write-first).

Ports:
- clk  in  1  single clock for everything.
- reset  in  1  synchronous, active-high.
- we_a  in  1  port A write enable.
- addr_a  in  ADDR_WIDTH  port A address.
- din_a  in  DATA_WIDTH  port A write data.
- dout_a  out  DATA_WIDTH  port A registered read data.
- we_b  in  1  port B write enable.
- addr_b  in  ADDR_WIDTH  port B address.
- din_b  in  DATA_WIDTH  port B write data.
- dout_b  out  DATA_WIDTH  port B registered read data.
- clr_start  in  1  one-cycle request to start a clear sweep.
- clr_value  in  DATA_WIDTH  fill value, sampled on the accepted clr_start cycle.
- clr_busy  out  1  high while the sweep is running.
- clr_done  out  1  one-cycle pulse when the sweep completes.

Behaviour:
- Reset: dout_a=0, dout_b=0, clr_busy=0, clr_done=0, FSM=IDLE, clear counter=0. RAM contents are not reset.
- Reads: every cycle each port registers the data at its address; dout_x is valid 1 cycle after addr_x is presented. There is no read enable.
- Writes: committed on the clk edge where we_x=1.
- Same-port read-during-write: RDW_MODE=0 gives the old word next cycle; RDW_MODE=1 gives din_x.
- Write collision (we_a=we_b=1, addr_a==addr_b): port A wins and din_b is discarded.
  - Cross-port read of that address: the other port's dout follows RDW_MODE (old word, or the winning written value).
- Clear FSM states: IDLE, CLEAR, DONE.
  - IDLE -> CLEAR on clr_start=1. Latch clr_value, counter=0, clr_busy=1 from the next cycle.
  - CLEAR: write the latched value to address=counter each cycle, then counter+1. When counter==2**ADDR_WIDTH-1, write the last word and go to DONE. A sweep takes exactly 2**ADDR_WIDTH cycles.
  - DONE: clr_done=1 and clr_busy=0 for one cycle, then IDLE.
- During CLEAR:
  - we_a and we_b are ignored (the clear write has priority).
  - Reads continue. A read of the address being cleared that cycle follows RDW_MODE (old word, or the fill value).
- clr_start while in CLEAR or DONE is ignored (not queued).
- reset mid-sweep: abort immediately. The FSM goes to IDLE with clr_busy=0 and no clr_done pulse. Already-cleared words keep the fill value; the rest are untouched.
- Counter width is ADDR_WIDTH+1 or a terminal compare, so there is no wrap before the last address is written.

Optional Feature:
- Macro: DPRAM_PARITY_EN.
- Defined:
  - Each word stores an extra even-parity bit computed from the write data (port or clear engine).
  - Adds outputs parity_err_a and parity_err_b (1 bit each, registered alongside dout_x, reset to 0). Each is high when the stored parity mismatches the stored data on that read.
- Undefined: no parity storage and no parity_err ports. Array width is exactly DATA_WIDTH.

Test Plan:
- Basic read/write, ADDR_WIDTH=4, DATA_WIDTH=2: write A addr 3=2'b10, then read B addr 3 -> dout_b=2'b10 exactly 1 cycle after the address.
- Collision: we_a=we_b=1, addr 5, din_a=01, din_b=11 -> later read of addr 5 gives 01.
- Read-during-write on port A: word at addr 7 = 00, write 11 to addr 7 while reading it -> dout_a=00 with RDW_MODE=0, 11 with RDW_MODE=1.
- Full clear: clr_start with clr_value=2'b01 -> clr_busy high for 16 cycles, single clr_done pulse. All 16 addresses read 01. A we_a issued mid-sweep does not change memory.
- Reset mid-clear: reset asserted after 6 sweep cycles -> clr_busy=0 next cycle, no clr_done. Addrs 0-5 hold the fill value, addrs 6-15 keep their prior data. A second clr_start during busy is ignored.
- With DPRAM_PARITY_EN: normal write/read -> parity_err=0. Bench forces a data-bit flip in the array -> parity_err_b=1 on that read.
